sample_accumulator: RTL and testbench



---
 rtl/accum_pkg.sv | 20 ++
 rtl/adder_16bit.sv | 22 ++
 rtl/sample_accumulator.sv | 112 +++++++++++
 tb/tb_sample_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared types and constants for the sample accumulator slice.
//  Revision    : 1.0  initial release
// ============================================================================
package accum_pkg;

    // Burst controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width of the shared adder datapath
    localparam int ADDER_WIDTH = 16;

endpackage : accum_pkg
`default_nettype wire

// File: rtl/adder_16bit.sv
`default_nettype none
// ============================================================================
//  Module      : adder_16bit
//  Description : Unsigned ripple adder with carry-in; the carry out of the MSB
//                is reported as overflow.
//  Revision    : 1.0  initial release
// ============================================================================
module adder_16bit
    import accum_pkg::*;
(
    input  logic [ADDER_WIDTH-1:0] a,
    input  logic [ADDER_WIDTH-1:0] b,
    input  logic                   carry_in,
    output logic [ADDER_WIDTH-1:0] sum,
    output logic                   overflow
);

    // Widen by one bit so the carry out lands in the top bit
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{ADDER_WIDTH{1'b0}}, carry_in};

endmodule : adder_16bit
`default_nettype wire

// File: rtl/sample_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : sample_accumulator
//  Description : Accepts a fixed-length burst of unsigned samples over a
//                valid/ready handshake, sums them through one adder_16bit and
//                presents the registered sum plus a sticky overflow flag over
//                a second valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module sample_accumulator
    import accum_pkg::*;
#(
    parameter int NUM_BITS    = 16,
    parameter int NUM_SAMPLES = 4,
    parameter int CNT_BITS    = $clog2(NUM_SAMPLES)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_valid,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_sum,
    output logic                out_overflow,
    output logic                busy
);

    // Index of the final sample of a burst
    localparam logic [CNT_BITS-1:0] c_last_idx = CNT_BITS'(NUM_SAMPLES - 1);
    localparam logic [CNT_BITS-1:0] c_cnt_one  = CNT_BITS'(1);

    state_t              r_state;
    logic [NUM_BITS-1:0] r_acc;
    logic [CNT_BITS-1:0] r_count;
    logic                r_sticky;
    logic [NUM_BITS-1:0] r_out_sum;
    logic                r_out_overflow;

    logic [NUM_BITS-1:0] w_sum;
    logic                w_carry;
    logic                w_xfer;
    logic                w_last;

    // Single shared adder: running total plus the incoming sample
    adder_16bit u_adder (
        .a        (r_acc),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (w_sum),
        .overflow (w_carry)
    );

    // A sample is consumed only while accumulating
    assign w_xfer = (r_state == ACCUM) && in_valid;
    assign w_last = (r_count == c_last_idx);

    // Burst controller and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_acc          <= '0;
            r_count        <= '0;
            r_sticky       <= 1'b0;
            r_out_sum      <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_sticky <= 1'b0;
                        r_state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_xfer) begin
                        r_acc    <= w_sum;
                        r_sticky <= r_sticky | w_carry;
                        if (w_last) begin
                            // Counter parks at the last index rather than wrapping
                            r_out_sum      <= w_sum;
                            r_out_overflow <= r_sticky | w_carry;
                            r_state        <= DONE;
                        end else begin
                            r_count <= r_count + c_cnt_one;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode only from the state register
    assign in_ready     = (r_state == ACCUM);
    assign out_valid    = (r_state == DONE);
    assign busy         = (r_state == ACCUM) || (r_state == DONE);
    assign out_sum      = r_out_sum;
    assign out_overflow = r_out_overflow;

endmodule : sample_accumulator
`default_nettype wire

// File: tb/tb_sample_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sample_accumulator
//  Description : Self-checking bench for sample_accumulator with bursts of
//                4, 2 and 256 samples, directed and randomized traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sample_accumulator;

    typedef logic [15:0] sample_q_t [$];

    logic        clk = 1'b0;
    logic        rst;
    logic        start        [3];
    logic        in_valid     [3];
    logic [15:0] in_data      [3];
    logic        in_ready     [3];
    logic        out_valid    [3];
    logic        out_ready    [3];
    logic [15:0] out_sum      [3];
    logic        out_overflow [3];
    logic        busy         [3];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instance 0: 4-sample bursts, 1: 2-sample bursts, 2: 256-sample bursts
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sample_accumulator #(
            .NUM_BITS    (16),
            .NUM_SAMPLES ((g == 0) ? 4 : ((g == 1) ? 2 : 256))
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start[g]),
            .in_valid     (in_valid[g]),
            .in_data      (in_data[g]),
            .in_ready     (in_ready[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_sum      (out_sum[g]),
            .out_overflow (out_overflow[g]),
            .busy         (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; everything after this is away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int k, input logic [15:0] exp_sum, input logic exp_ovf);
        check_eq("idle_busy", 32'(busy[k]), 32'd0);
        check_eq("idle_in_ready", 32'(in_ready[k]), 32'd0);
        check_eq("idle_out_valid", 32'(out_valid[k]), 32'd0);
        check_eq("idle_out_sum", 32'(out_sum[k]), 32'(exp_sum));
        check_eq("idle_out_overflow", 32'(out_overflow[k]), 32'(exp_ovf));
    endtask

    // One complete burst on instance k. gap_mode: 0 none, 1 every other
    // cycle, 2 random. The reference is the plain arithmetic sum: the burst
    // carried out at some step exactly when the true total reaches 2^16.
    task automatic run_burst(input int k, input sample_q_t s, input int gap_mode,
                             input bit mid_start, input int hold);
        int unsigned total;
        logic [15:0] exp_sum;
        logic        exp_ovf;
        int          ng;
        total = 0;
        foreach (s[i]) total += 32'(s[i]);
        exp_sum = total[15:0];
        exp_ovf = (total > 32'h0000_FFFF);

        start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        check_eq("start_busy", 32'(busy[k]), 32'd1);

        for (int i = 0; i < s.size(); i++) begin
            ng = (gap_mode == 1) ? 1 : ((gap_mode == 2) ? int'($urandom_range(0, 2)) : 0);
            for (int j = 0; j < ng; j++) begin
                in_valid[k] = 1'b0;
                in_data[k]  = 16'($urandom);
                tick();
            end
            if (mid_start && i == 2) start[k] = 1'b1;
            check_eq("accum_in_ready", 32'(in_ready[k]), 32'd1);
            check_eq("no_early_valid", 32'(out_valid[k]), 32'd0);
            in_valid[k] = 1'b1;
            in_data[k]  = s[i];
            tick();
            in_valid[k] = 1'b0;
            start[k]    = 1'b0;
        end

        check_eq("done_out_valid", 32'(out_valid[k]), 32'd1);
        check_eq("done_out_sum", 32'(out_sum[k]), 32'(exp_sum));
        check_eq("done_out_overflow", 32'(out_overflow[k]), 32'(exp_ovf));
        check_eq("done_busy", 32'(busy[k]), 32'd1);
        check_eq("done_in_ready", 32'(in_ready[k]), 32'd0);

        // Backpressure with distracting inputs
        for (int h = 0; h < hold; h++) begin
            in_valid[k]  = 1'b1;
            in_data[k]   = 16'hAAAA;
            start[k]     = 1'($urandom_range(0, 1));
            out_ready[k] = 1'b0;
            tick();
            check_eq("hold_out_valid", 32'(out_valid[k]), 32'd1);
            check_eq("hold_out_sum", 32'(out_sum[k]), 32'(exp_sum));
            check_eq("hold_out_overflow", 32'(out_overflow[k]), 32'(exp_ovf));
            check_eq("hold_in_ready", 32'(in_ready[k]), 32'd0);
        end

        // Handshake cycle; start here must be ignored
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        in_data[k]   = 16'hAAAA;
        start[k]     = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        in_valid[k]  = 1'b0;
        start[k]     = 1'b0;
        check_idle(k, exp_sum, exp_ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sample_q_t q;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; in_valid[k] = 1'b0; in_data[k] = '0; out_ready[k] = 1'b0;
        end
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) check_idle(k, 16'h0000, 1'b0);

        // Basic burst
        q = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_burst(0, q, 0, 1'b0, 0);

        // Sticky overflow, then a clean burst clears it
        q = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000};
        run_burst(0, q, 0, 1'b0, 0);
        q = '{16'd1, 16'd1, 16'd1, 16'd1};
        run_burst(0, q, 0, 1'b0, 0);

        // Gaps and backpressure
        q = '{16'h1000, 16'h1000, 16'h1000, 16'h1000};
        run_burst(0, q, 1, 1'b0, 5);

        // Reset mid-burst discards the partial sum
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        in_valid[0] = 1'b1; in_data[0] = 16'd7; tick();
        in_data[0] = 16'd9; tick();
        in_valid[0] = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check_idle(0, 16'h0000, 1'b0);
        q = '{16'd5, 16'd5, 16'd5, 16'd5};
        run_burst(0, q, 0, 1'b0, 0);

        // in_valid in IDLE is not consumed; start mid-burst is ignored
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            in_data[0]  = 16'($urandom);
            tick();
            check_eq("idle_ignore_in_ready", 32'(in_ready[0]), 32'd0);
            check_eq("idle_ignore_busy", 32'(busy[0]), 32'd0);
        end
        in_valid[0] = 1'b0;
        q = '{16'd10, 16'd20, 16'd30, 16'd40};
        run_burst(0, q, 0, 1'b1, 0);

        // Parameter sweep
        q = '{16'h8000, 16'h8000};
        run_burst(1, q, 0, 1'b0, 1);
        q = {};
        for (int i = 0; i < 256; i++) q.push_back(16'h0100);
        run_burst(2, q, 0, 1'b0, 0);

        // Randomized bursts, biased toward large values to provoke carries
        for (int r = 0; r < 30; r++) begin
            int k;
            int n;
            k = (r % 3 == 2) ? 1 : 0;
            n = (k == 0) ? 4 : 2;
            q = {};
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 2) == 0) q.push_back(16'hFFFF - 16'($urandom_range(0, 15)));
                else                           q.push_back(16'($urandom));
            end
            run_burst(k, q, 2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sample_accumulator
`default_nettype wire
